// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life generation stepper.
// Grid defaults, neighbour-count width, rule thresholds and FSM states.
package life_pkg;

   localparam int LIFE_ROWS = 16;
   localparam int LIFE_COLS = 16;
   localparam int NBR_CNT_W = 4;

   localparam logic [NBR_CNT_W-1:0] BIRTH   = 4'd3;
   localparam logic [NBR_CNT_W-1:0] SURVIVE = 4'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      COMMIT  = 2'd2
   } life_state_e;

endpackage

// File: rtl/life_nbr_count.sv
// Popcount of a cell's eight neighbour alive bits, giving 0..8.
module life_nbr_count
   import life_pkg::*;
(
   input  logic [7:0]           nbrs,
   output logic [NBR_CNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < 8; i++) begin
         count = count + {{(NBR_CNT_W-1){1'b0}}, nbrs[i]};
      end
   end

endmodule

// File: rtl/life_gen_engine.sv
// Game-of-Life generation stepper: evaluates one row of the next generation
// per cycle from the stable current grid, then commits the whole grid at once.
module life_gen_engine
   import life_pkg::*;
#(
   parameter int ROWS = LIFE_ROWS,
   parameter int COLS = LIFE_COLS,
   parameter bit WRAP = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid,
   input  logic [$clog2(ROWS)-1:0] load_row_idx,
   input  logic [COLS-1:0]         load_row_data,
   input  logic                    step,
   input  logic [$clog2(ROWS)-1:0] rd_row_idx,
   output logic [COLS-1:0]         rd_row_data,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             gen_count,
   output logic                    alive_any
);

   localparam int RW = $clog2(ROWS);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   life_state_e     state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [15:0]     gen_count_q, gen_count_d;
   logic [COLS-1:0] cur_q [ROWS];
   logic [COLS-1:0] cur_d [ROWS];
   logic [COLS-1:0] nxt_q [ROWS];
   logic [COLS-1:0] nxt_d [ROWS];

   logic [RW-1:0]   row_up_idx, row_dn_idx;
   logic [COLS-1:0] row_up, row_mid, row_dn;
   logic [COLS-1:0] new_row;

   // Neighbour rows for the row being evaluated; without wrap the rows beyond
   // the top and bottom edges read as dead.
   always_comb begin
      row_up_idx = (row_q == '0) ? ROW_LAST : row_q - 1'b1;
      row_dn_idx = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      row_up     = cur_q[row_up_idx];
      row_mid    = cur_q[row_q];
      row_dn     = cur_q[row_dn_idx];
      if (!WRAP && (row_q == '0)) row_up = '0;
      if (!WRAP && (row_q == ROW_LAST)) row_dn = '0;
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int CL    = (c == 0) ? COLS - 1 : c - 1;
      localparam int CR    = (c == COLS - 1) ? 0 : c + 1;
      localparam bit HAS_L = WRAP || (c != 0);
      localparam bit HAS_R = WRAP || (c != COLS - 1);

      logic [7:0]           nbrs;
      logic [NBR_CNT_W-1:0] count;

      assign nbrs = {HAS_L ? row_up[CL]  : 1'b0, row_up[c], HAS_R ? row_up[CR]  : 1'b0,
                     HAS_L ? row_mid[CL] : 1'b0,            HAS_R ? row_mid[CR] : 1'b0,
                     HAS_L ? row_dn[CL]  : 1'b0, row_dn[c], HAS_R ? row_dn[CR]  : 1'b0};

      life_nbr_count u_nbr_count (
         .nbrs  (nbrs),
         .count (count)
      );

      assign new_row[c] = (count == BIRTH) | (row_mid[c] & (count == SURVIVE));
   end

   // Sequencing: loads and step requests are only accepted in IDLE, so a load
   // issued together with step lands before row 0 is evaluated.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      gen_count_d = gen_count_q;
      cur_d       = cur_q;
      nxt_d       = nxt_q;
      case (state_q)
         IDLE: begin
            if (load_valid) cur_d[load_row_idx] = load_row_data;
            if (step) begin
               state_d = COMPUTE;
               row_d   = '0;
            end
         end
         COMPUTE: begin
            nxt_d[row_q] = new_row;
            if (row_q == ROW_LAST) begin
               row_d   = '0;
               state_d = COMMIT;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         COMMIT: begin
            cur_d       = nxt_q;
            gen_count_d = gen_count_q + 16'd1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         row_q       <= '0;
         gen_count_q <= '0;
         cur_q       <= '{default: '0};
         nxt_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         gen_count_q <= gen_count_d;
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
      end
   end

   always_comb begin
      alive_any = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         alive_any = alive_any | (|cur_q[r]);
      end
   end

   assign rd_row_data = cur_q[rd_row_idx];
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == COMMIT);
   assign gen_count   = gen_count_q;

endmodule
